// File: rtl/pio_pkg.sv
// rtl/pio_pkg.sv - register map and defaults shared by the debounced edge-capture PIO
package pio_pkg;

  localparam logic [2:0] PIO_ADDR_DATA     = 3'd0;
  localparam logic [2:0] PIO_ADDR_RAW      = 3'd1;
  localparam logic [2:0] PIO_ADDR_MASK     = 3'd2;
  localparam logic [2:0] PIO_ADDR_EDGE     = 3'd3;
  localparam logic [2:0] PIO_ADDR_RISE     = 3'd4;
  localparam logic [2:0] PIO_ADDR_FALL     = 3'd5;
  localparam logic [2:0] PIO_ADDR_DEBOUNCE = 3'd6;

  localparam int PIO_DEBOUNCE_DEFAULT = 50000;

endpackage

// File: rtl/pio_debounce_chan.sv
// rtl/pio_debounce_chan.sv - one input bit: synchroniser, debounce counter, debounced q and its delayed copy
module pio_debounce_chan #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_pin,
  input  logic [CNT_W-1:0] i_period,
  input  logic             i_clr_cnt,
  output logic             o_s,
  output logic             o_q,
  output logic             o_q_d
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_q;
  logic                   r_q_d;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
    end
  end

  // A period rewrite restarts the count but leaves q alone; the old period is irrelevant then.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_q   <= 1'b0;
      r_q_d <= 1'b0;
    end else begin
      r_q_d <= r_q;
      if (i_clr_cnt) begin
        r_cnt <= '0;
      end else if (i_period == '0) begin
        r_q   <= w_s;
        r_cnt <= '0;
      end else if (w_s == r_q) begin
        r_cnt <= '0;
      end else if (r_cnt == i_period - CNT_W'(1)) begin
        r_q   <= w_s;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_s   = w_s;
  assign o_q   = r_q;
  assign o_q_d = r_q_d;

endmodule

// File: rtl/pio_debounced_edge_irq.sv
// rtl/pio_debounced_edge_irq.sv - Avalon-MM debounced input PIO with per-bit edge capture and maskable irq
module pio_debounced_edge_irq
  import pio_pkg::*;
#(
  parameter int               WIDTH        = 4,
  parameter int               SYNC_STAGES  = 2,
  parameter int               CNT_W        = 16,
  parameter logic [CNT_W-1:0] DEBOUNCE_RST = CNT_W'(PIO_DEBOUNCE_DEFAULT),
  parameter logic [WIDTH-1:0] RISE_RST     = '1,
  parameter logic [WIDTH-1:0] FALL_RST     = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic             w_wr;
  logic             w_wr_period;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_q_d;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_w1c;
  logic [31:0]      w_rd;
  logic             w_unused_wdata;

  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [CNT_W-1:0] r_period;
  logic [31:0]      r_readdata;

  assign w_wr           = chipselect & ~write_n;
  assign w_wr_period    = w_wr && (address == PIO_ADDR_DEBOUNCE);
  assign w_unused_wdata = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    pio_debounce_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_pin     (in_port[i]),
      .i_period  (r_period),
      .i_clr_cnt (w_wr_period),
      .o_s       (w_s[i]),
      .o_q       (w_q[i]),
      .o_q_d     (w_q_d[i])
    );
  end

  assign w_rise = w_q & ~w_q_d & r_rise_en;
  assign w_fall = ~w_q & w_q_d & r_fall_en;
  assign w_w1c  = (w_wr && (address == PIO_ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask    <= '0;
      r_rise_en <= RISE_RST;
      r_fall_en <= FALL_RST;
      r_period  <= DEBOUNCE_RST;
    end else if (w_wr) begin
      case (address)
        PIO_ADDR_MASK:     r_mask    <= writedata[WIDTH-1:0];
        PIO_ADDR_RISE:     r_rise_en <= writedata[WIDTH-1:0];
        PIO_ADDR_FALL:     r_fall_en <= writedata[WIDTH-1:0];
        PIO_ADDR_DEBOUNCE: r_period  <= writedata[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  // New edges are OR-ed in after the clear so a coincident W1C cannot lose one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edge <= '0;
    end else begin
      r_edge <= (r_edge & ~w_w1c) | w_rise | w_fall;
    end
  end

  always_comb begin
    w_rd = '0;
    case (address)
      PIO_ADDR_DATA:     w_rd[WIDTH-1:0] = w_q;
      PIO_ADDR_RAW:      w_rd[WIDTH-1:0] = w_s;
      PIO_ADDR_MASK:     w_rd[WIDTH-1:0] = r_mask;
      PIO_ADDR_EDGE:     w_rd[WIDTH-1:0] = r_edge;
      PIO_ADDR_RISE:     w_rd[WIDTH-1:0] = r_rise_en;
      PIO_ADDR_FALL:     w_rd[WIDTH-1:0] = r_fall_en;
      PIO_ADDR_DEBOUNCE: w_rd[CNT_W-1:0] = r_period;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rd;
    end
  end

  assign readdata = r_readdata;
  assign irq      = |(r_edge & r_mask);

endmodule

// File: tb/tb_pio_debounced_edge_irq.sv
// tb/tb_pio_debounced_edge_irq.sv - scoreboard bench for the debounced edge-capture PIO
module tb_pio_debounced_edge_irq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [3:0]  in_port = 4'd0;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    logic        chk_irq;
    logic        irq;
    string       name;
  } sb_entry_t;

  sb_entry_t sb[$];
  sb_entry_t mon_e;
  logic      rd_req = 1'b0;
  logic      rd_vld = 1'b0;

  pio_debounced_edge_irq dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_vld <= rd_req;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd_vld) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow: got read with no expectation expected queued entry");
      end else begin
        mon_e = sb.pop_front();
        chk(mon_e.name, readdata, mon_e.data);
        if (mon_e.chk_irq) chk({mon_e.name, "_irq"}, {31'd0, irq}, {31'd0, mon_e.irq});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    @(posedge clk);
    #1;
    write_n = 1'b1;
    chipselect = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input logic ci,
                    input logic ei, input string nm);
    sb_entry_t e;
    e.data = exp;
    e.chk_irq = ci;
    e.irq = ei;
    e.name = nm;
    sb.push_back(e);
    address = a;
    chipselect = 1'b1;
    write_n = 1'b1;
    rd_req = 1'b1;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    chipselect = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  logic [31:0] reset_exp [8] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hF, 32'd0, 32'd50000, 32'd0};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_readdata", readdata, 32'd0);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;

    for (int a = 0; a < 8; a++) rd(3'(a), reset_exp[a], 1'b1, 1'b0, $sformatf("reset_addr%0d", a));
    wr(3'd1, 32'hF);
    wr(3'd7, 32'hF);
    rd(3'd1, 32'd0, 1'b0, 1'b0, "raw_ro");
    rd(3'd7, 32'd0, 1'b0, 1'b0, "addr7_zero");

    // debounced rise, P=4: capture and irq exactly 7 edges after the pin change
    wr(3'd6, 32'd4);
    wr(3'd2, 32'h1);
    idle(2);
    in_port[0] = 1'b1;
    for (int k = 1; k <= 8; k++)
      rd(3'd3, (k == 8) ? 32'h1 : 32'h0, 1'b1, (k >= 7), $sformatf("rise_edge%0d", k));
    rd(3'd0, 32'h1, 1'b0, 1'b0, "rise_q");
    wr(3'd3, 32'h1);
    rd(3'd3, 32'h0, 1'b1, 1'b0, "rise_clear");

    // glitch rejection: 3-cycle pulse ignored, 4-cycle pulse captured
    in_port[1] = 1'b1;
    idle(3);
    in_port[1] = 1'b0;
    idle(10);
    rd(3'd3, 32'h0, 1'b1, 1'b0, "glitch3_edge");
    rd(3'd0, 32'h1, 1'b0, 1'b0, "glitch3_q");
    in_port[1] = 1'b1;
    idle(4);
    in_port[1] = 1'b0;
    idle(12);
    rd(3'd3, 32'h2, 1'b1, 1'b0, "pulse4_edge");
    rd(3'd0, 32'h1, 1'b0, 1'b0, "pulse4_q");
    wr(3'd3, 32'h2);

    // falling-only capture on bit 2
    wr(3'd4, 32'h0);
    wr(3'd5, 32'h4);
    in_port[2] = 1'b1;
    idle(10);
    rd(3'd3, 32'h0, 1'b0, 1'b0, "fall_after_rise");
    in_port[2] = 1'b0;
    idle(10);
    rd(3'd3, 32'h4, 1'b0, 1'b0, "fall_after_fall");
    wr(3'd3, 32'h4);
    rd(3'd3, 32'h0, 1'b0, 1'b0, "fall_clear");

    // W1C colliding with a new edge on bit 3: set wins
    wr(3'd4, 32'h8);
    wr(3'd5, 32'h8);
    wr(3'd2, 32'h8);
    in_port[3] = 1'b1;
    idle(10);
    rd(3'd3, 32'h8, 1'b1, 1'b1, "w1c_first");
    in_port[3] = 1'b0;
    idle(6);
    wr(3'd3, 32'h8);
    rd(3'd3, 32'h8, 1'b1, 1'b1, "w1c_collide");
    wr(3'd3, 32'h8);
    chk("w1c_irq_drop", {31'd0, irq}, 32'd0);
    rd(3'd3, 32'h0, 1'b1, 1'b0, "w1c_clear");

    // bypass: P=0 captures 4 edges after the pin change
    wr(3'd6, 32'd0);
    wr(3'd4, 32'h1);
    wr(3'd5, 32'h0);
    wr(3'd2, 32'h1);
    in_port[0] = 1'b0;
    idle(5);
    rd(3'd3, 32'h0, 1'b1, 1'b0, "bypass_fall_ignored");
    in_port[0] = 1'b1;
    for (int k = 1; k <= 5; k++)
      rd(3'd3, (k == 5) ? 32'h1 : 32'h0, 1'b1, (k >= 4), $sformatf("bypass_edge%0d", k));
    wr(3'd3, 32'h1);

    // reprogram P=4 -> P=8 mid-count: q changes 8 cycles after the write
    wr(3'd6, 32'd4);
    in_port[0] = 1'b0;
    idle(4);
    wr(3'd6, 32'd8);
    for (int k = 6; k <= 14; k++)
      rd(3'd0, (k == 14) ? 32'h0 : 32'h1, 1'b0, 1'b0, $sformatf("reprog_q%0d", k));
    rd(3'd6, 32'd8, 1'b0, 1'b0, "reprog_period");

    // asynchronous reset with a capture pending
    wr(3'd6, 32'd0);
    in_port[0] = 1'b1;
    idle(6);
    rd(3'd3, 32'h1, 1'b1, 1'b1, "prereset_edge");
    idle(1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_readdata", readdata, 32'd0);
    chk("async_reset_irq", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    rd(3'd3, 32'h0, 1'b1, 1'b0, "postreset_edge");
    rd(3'd6, 32'd50000, 1'b0, 1'b0, "postreset_period");
    rd(3'd0, 32'h0, 1'b0, 1'b0, "postreset_q");
    rd(3'd2, 32'h0, 1'b0, 1'b0, "postreset_mask");

    idle(3);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
